// File: rtl/clk_speed_controller.sv
// Button-driven tap selector for clk_divider with glitch-free re-emission of the divided clock.
// Optional macro DEBOUNCE_EN adds a stable-count filter on each synchronized button.
module clk_speed_controller #(
    parameter int unsigned SIZE            = 32,
    parameter int unsigned DEFAULT_SEL     = 24,
    parameter int unsigned MIN_SEL         = 0,
    parameter int unsigned MAX_SEL         = SIZE - 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     block_clk,
    output logic [$clog2(SIZE)-1:0]  speed_selector,
    output logic                     clk_out,
    output logic                     busy,
    output logic                     sel_changed
);

    localparam int unsigned SelW = $clog2(SIZE);
    localparam logic [SelW-1:0] MinSel = SelW'(MIN_SEL);
    localparam logic [SelW-1:0] MaxSel = SelW'(MAX_SEL);
    localparam logic [SelW-1:0] DefSel = SelW'(DEFAULT_SEL);

    if (DEBOUNCE_CYCLES == 0 || MAX_SEL >= SIZE || MIN_SEL > MAX_SEL ||
        DEFAULT_SEL < MIN_SEL || DEFAULT_SEL > MAX_SEL) begin : g_param_check
        $error("clk_speed_controller: inconsistent parameters");
    end

    typedef enum logic [1:0] {StIdle, StDrain, StSwitch, StSettle} state_e;

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0] sync1_q, sync2_q, edge_prev_q, lvl, press_p;
    logic       up_p, down_p;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            edge_prev_q <= '0;
        end else begin
            sync1_q     <= {btn_down, btn_up};
            sync2_q     <= sync1_q;
            edge_prev_q <= lvl;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] db_cnt_q [2];
    logic [CntW-1:0] db_cnt_d [2];
    logic [1:0]      filt_q, filt_d;

    // Any cycle where the raw level agrees with the filtered one restarts the count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == CntLast) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            filt_q      <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            filt_q      <= filt_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    assign press_p = lvl & ~edge_prev_q;
    assign up_p    = press_p[0];
    assign down_p  = press_p[1];

    state_e          state_q, state_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [SelW-1:0] target_q, target_d;
    logic [1:0]      settle_q, settle_d;
    logic            gate_en_q, gate_en_d;
    logic            blk_q;
    logic            clk_out_q, clk_out_d;
    logic            sel_changed_q, sel_changed_d;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        target_d      = target_q;
        settle_d      = settle_q;
        gate_en_d     = gate_en_q;
        sel_changed_d = 1'b0;
        clk_out_d     = blk_q & gate_en_q;

        unique case (state_q)
            StIdle: begin
                if (up_p && !down_p && sel_q < MaxSel) begin
                    target_d = sel_q + SelW'(1);
                    state_d  = StDrain;
                end else if (down_p && !up_p && sel_q > MinSel) begin
                    target_d = sel_q - SelW'(1);
                    state_d  = StDrain;
                end
            end
            // Close the gate only while the divided clock is low so no high is cut short.
            StDrain: begin
                if (!blk_q) begin
                    gate_en_d = 1'b0;
                    state_d   = StSwitch;
                end
            end
            StSwitch: begin
                sel_d    = target_q;
                settle_d = '0;
                state_d  = StSettle;
            end
            // Two cycles let blk_q pick up the new tap before reopening on a low phase.
            StSettle: begin
                if (settle_q != 2'd2) begin
                    settle_d = settle_q + 2'd1;
                end else if (!blk_q) begin
                    gate_en_d     = 1'b1;
                    sel_changed_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            sel_q         <= DefSel;
            target_q      <= DefSel;
            settle_q      <= '0;
            gate_en_q     <= 1'b1;
            blk_q         <= 1'b0;
            clk_out_q     <= 1'b0;
            sel_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            target_q      <= target_d;
            settle_q      <= settle_d;
            gate_en_q     <= gate_en_d;
            blk_q         <= block_clk;
            clk_out_q     <= clk_out_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    assign speed_selector = sel_q;
    assign clk_out        = clk_out_q;
    assign busy           = (state_q != StIdle);
    assign sel_changed    = sel_changed_q;

endmodule

// File: doc/clk_speed_controller.md
Name: clk_speed_controller

Overview:
- Run-time controller for the clk_divider tap. It turns up/down button presses into a saturating speed_selector value.
- Changes the tap only at safe points and re-emits the divided clock as a registered, glitch-free clk_out.
- Sits between the board buttons, the divider (drives speed_selector, observes block_clk) and the downstream blocks clocked or enabled by clk_out.

Parameters:
- SIZE, 32, divider counter width; speed_selector width is $clog2(SIZE).
- DEFAULT_SEL, 24, selector value loaded at reset.
- MIN_SEL, 0, lowest selectable tap (fastest).
- MAX_SEL, SIZE-1, highest selectable tap (slowest).
- DEBOUNCE_CYCLES, 1000000, stable-cycle count for the button filter (used only with DEBOUNCE_EN).

Ports:
- sys_clk  in  1  system clock; everything is on posedge.
- sys_rst_n  in  1  asynchronous active-low reset.
- btn_up  in  1  raw async button, active high; request one step slower (selector +1).
- btn_down  in  1  raw async button, active high; request one step faster (selector -1).
- block_clk  in  1  divided clock from clk_divider, synchronous to sys_clk.
- speed_selector  out  $clog2(SIZE)  registered tap select to clk_divider.
- clk_out  out  1  registered, gated copy of block_clk.
- busy  out  1  high while a tap change is in progress.
- sel_changed  out  1  one-cycle pulse when a change completes.

Behaviour:
- Reset (async assert, sync release) sets: speed_selector=DEFAULT_SEL, clk_out=0, busy=0, sel_changed=0, gate_en=1, blk_q=0, FSM=IDLE, all sync/debounce/edge state cleared.
- Input path: each button passes through a 2-flop synchronizer, then the filter (see Optional Feature), then a rising-edge detector. The result is a one-cycle up_p/down_p pulse per press. Holding a button produces no repeats.
- blk_q is block_clk registered every cycle. clk_out <= blk_q & gate_en, so clk_out lags block_clk by 2 cycles and is never combinational.
- FSM states: IDLE, DRAIN, SWITCH, SETTLE. busy = (state != IDLE).
- IDLE:
  - up_p alone with sel<MAX_SEL: target=sel+1, go to DRAIN.
  - down_p alone with sel>MIN_SEL: target=sel-1, go to DRAIN.
  - up_p and down_p in the same cycle: ignored.
  - A request at the limit is ignored: no state change, no sel_changed.
- DRAIN: wait for blk_q==0, then gate_en<=0 and go to SWITCH. clk_out therefore falls or stays low; no high pulse is truncated.
- SWITCH: one cycle; speed_selector<=target; clear settle counter; go to SETTLE.
- SETTLE: wait at least 2 cycles so blk_q reflects the new tap, then wait for blk_q==0. On that cycle: gate_en<=1, sel_changed=1 for one cycle, go to IDLE.
- Output guarantee: every clk_out high pulse lasts exactly 2^sel cycles of the selector in effect. No runt highs or lows shorter than one sys_clk cycle. clk_out may hold low longer than nominal during a change.
- Presses arriving while busy=1 are dropped, not queued.
- Reset asserted in any state returns to the reset values immediately. A partially applied change is abandoned and the selector returns to DEFAULT_SEL.
- Selector arithmetic is in $clog2(SIZE) bits. Range checks occur before the +/-1, so the value never wraps.
- Per-press latency from a clean press to sel_changed: filter latency + 1 (edge) + DRAIN wait (≤2^sel cycles) + 1 (SWITCH) + SETTLE (≥2, ≤2+2^target cycles).

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - Each synchronized button feeds a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The filtered level updates only after the raw synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break resets the counter.
  - Edge detection runs on the filtered level.
- Undefined:
  - No counters; edge detection runs directly on the synchronizer output.
  - Press-to-pulse latency is 3 cycles; bounce can produce extra steps, limited only by busy-drop.

Test Plan (SIZE=8, DEFAULT_SEL=3, MIN_SEL=0, MAX_SEL=7, DEBOUNCE_CYCLES=4, DEBOUNCE_EN defined unless noted):
- Reset with block_clk from a real clk_divider: speed_selector=3, busy=0, clk_out=0. After release, clk_out is a 16-cycle-period square wave lagging block_clk by 2 cycles.
- btn_up held 20 cycles: exactly one sel_changed pulse, speed_selector 3->4, busy high only between request and sel_changed. All clk_out high pulses are 8 or 16 cycles; none shorter.
- Saturation: at speed_selector=7, press btn_up: no busy, no sel_changed. Step down to 0, press btn_down: likewise, selector stays 0.
- btn_up and btn_down rise in the same cycle and are held 10 cycles: no change, busy stays 0.
- Bounce: btn_up toggles every 2 cycles for 20 cycles, then stays low: no change with DEBOUNCE_EN. Without DEBOUNCE_EN: at least one step, and sel_changed count equals the number of selector changes.
- Assert sys_rst_n=0 mid-SETTLE (3->4 in progress): asynchronously speed_selector=3, busy=0, clk_out=0, sel_changed=0. Normal operation resumes after release.
